// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_input_conditioner
//  Description : Conditions raw board inputs before the GPIO register block
//                samples them. Each switch and GPIO bit goes through a 2-FF
//                synchroniser, a tick-based debounce filter and an edge-pulse
//                generator. GPIO bits configured as outputs are masked to 0.
//
//  Ports
//    clk          in   1       system clock
//    rst_n        in   1       asynchronous reset, active low
//    sw_pad_i     in   SW_W    raw switch levels, asynchronous
//    gpio_pad_i   in   GPIO_W  raw pin levels, asynchronous
//    gpio_dir_i   in   GPIO_W  pin direction from CSR (1 = output)
//    sw_o         out  SW_W    debounced switches
//    gpio_o       out  GPIO_W  debounced, direction-masked pins
//    sw_rise_o    out  SW_W    1-cycle pulse on each 0->1 change of sw_o
//    sw_fall_o    out  SW_W    1-cycle pulse on each 1->0 change of sw_o
//    gpio_edge_o  out  GPIO_W  1-cycle pulse on any change of gpio_o
//
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_input_conditioner #(
    parameter int SW_W         = 4,
    parameter int GPIO_W       = 12,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SW_W-1:0]   sw_pad_i,
    input  logic [GPIO_W-1:0] gpio_pad_i,
    input  logic [GPIO_W-1:0] gpio_dir_i,
    output logic [SW_W-1:0]   sw_o,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [SW_W-1:0]   sw_rise_o,
    output logic [SW_W-1:0]   sw_fall_o,
    output logic [GPIO_W-1:0] gpio_edge_o
);

    localparam int CW = $clog2(STABLE_TICKS) + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] c_pcnt_max  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] c_cnt_last  = CW'(STABLE_TICKS - 1);

    // ------------------------------------------------------------------
    // Prescaler: one-cycle tick every TICK_DIV cycles. With TICK_DIV==1
    // the counter is pinned at 0 and the tick is permanently high.
    // ------------------------------------------------------------------
    logic [PW-1:0] r_pcnt;
    logic          w_tick;

    assign w_tick = (r_pcnt == c_pcnt_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Two-stage synchronisers; only the second stage feeds the filters.
    // ------------------------------------------------------------------
    logic [SW_W-1:0]   r_sw_s1,   r_sw_s2;
    logic [GPIO_W-1:0] r_gpio_s1, r_gpio_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_gpio_s1 <= '0;
            r_gpio_s2 <= '0;
        end else begin
            r_sw_s1   <= sw_pad_i;
            r_sw_s2   <= r_sw_s1;
            r_gpio_s1 <= gpio_pad_i;
            r_gpio_s2 <= r_gpio_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce filters. The debounced-state register is the output
    // register itself, so the output follows the pad after the sync
    // stages plus STABLE_TICKS ticks with no extra pipeline stage.
    // Any cycle where the synchronised level equals the debounced state
    // clears the counter, so a glitch that returns early is discarded.
    // ------------------------------------------------------------------
    logic [SW_W-1:0]   r_sw_db,   w_sw_db_nxt;
    logic [GPIO_W-1:0] r_gpio_db, w_gpio_db_nxt;
    logic [CW-1:0]     r_sw_cnt     [SW_W];
    logic [CW-1:0]     w_sw_cnt_nxt [SW_W];
    logic [CW-1:0]     r_gpio_cnt     [GPIO_W];
    logic [CW-1:0]     w_gpio_cnt_nxt [GPIO_W];

    always_comb begin
        w_sw_db_nxt = r_sw_db;
        for (int i = 0; i < SW_W; i++) begin
            w_sw_cnt_nxt[i] = r_sw_cnt[i];
            if (r_sw_s2[i] == r_sw_db[i]) begin
                w_sw_cnt_nxt[i] = '0;
            end else if (w_tick && (r_sw_cnt[i] == c_cnt_last)) begin
                w_sw_db_nxt[i]  = r_sw_s2[i];
                w_sw_cnt_nxt[i] = '0;
            end else if (w_tick) begin
                w_sw_cnt_nxt[i] = r_sw_cnt[i] + CW'(1);
            end
        end
    end

    // Pins driven as outputs are held at db=0/cnt=0, which both masks
    // gpio_o on the cycle after dir rises and makes a later return to
    // input mode debounce from a clean 0 state.
    always_comb begin
        w_gpio_db_nxt = r_gpio_db;
        for (int i = 0; i < GPIO_W; i++) begin
            w_gpio_cnt_nxt[i] = r_gpio_cnt[i];
            if (gpio_dir_i[i]) begin
                w_gpio_db_nxt[i]  = 1'b0;
                w_gpio_cnt_nxt[i] = '0;
            end else if (r_gpio_s2[i] == r_gpio_db[i]) begin
                w_gpio_cnt_nxt[i] = '0;
            end else if (w_tick && (r_gpio_cnt[i] == c_cnt_last)) begin
                w_gpio_db_nxt[i]  = r_gpio_s2[i];
                w_gpio_cnt_nxt[i] = '0;
            end else if (w_tick) begin
                w_gpio_cnt_nxt[i] = r_gpio_cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_db   <= '0;
            r_gpio_db <= '0;
            for (int i = 0; i < SW_W; i++) begin
                r_sw_cnt[i] <= '0;
            end
            for (int i = 0; i < GPIO_W; i++) begin
                r_gpio_cnt[i] <= '0;
            end
        end else begin
            r_sw_db   <= w_sw_db_nxt;
            r_gpio_db <= w_gpio_db_nxt;
            for (int i = 0; i < SW_W; i++) begin
                r_sw_cnt[i] <= w_sw_cnt_nxt[i];
            end
            for (int i = 0; i < GPIO_W; i++) begin
                r_gpio_cnt[i] <= w_gpio_cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge pulses: compare the output register with its value one cycle
    // earlier, registered, so a pulse appears in the cycle after the
    // output change and lasts exactly one cycle.
    // ------------------------------------------------------------------
    logic [SW_W-1:0]   r_sw_prev,   r_sw_rise, r_sw_fall;
    logic [GPIO_W-1:0] r_gpio_prev, r_gpio_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_prev   <= '0;
            r_sw_rise   <= '0;
            r_sw_fall   <= '0;
            r_gpio_prev <= '0;
            r_gpio_edge <= '0;
        end else begin
            r_sw_prev   <= r_sw_db;
            r_sw_rise   <= r_sw_db & ~r_sw_prev;
            r_sw_fall   <= ~r_sw_db & r_sw_prev;
            r_gpio_prev <= r_gpio_db;
            r_gpio_edge <= r_gpio_db ^ r_gpio_prev;
        end
    end

    assign sw_o        = r_sw_db;
    assign gpio_o      = r_gpio_db;
    assign sw_rise_o   = r_sw_rise;
    assign sw_fall_o   = r_sw_fall;
    assign gpio_edge_o = r_gpio_edge;

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_input_conditioner
//  Description : Self-checking bench for gpio_input_conditioner. One instance
//                uses TICK_DIV=4/STABLE_TICKS=3, a second uses 1/1. Expected
//                pulse events (kind, bit, cycle window) are queued as stimulus
//                is applied and popped by a monitor as pulses appear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_input_conditioner;

    localparam int SW_W   = 4;
    localparam int GPIO_W = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [SW_W-1:0]   sw_pad   = '0;
    logic [GPIO_W-1:0] gpio_pad = '0;
    logic [GPIO_W-1:0] gpio_dir = '0;
    logic [SW_W-1:0]   sw_o, sw_rise, sw_fall;
    logic [GPIO_W-1:0] gpio_o, gpio_edge;

    logic [SW_W-1:0]   sw_pad1   = '0;
    logic [GPIO_W-1:0] gpio_pad1 = '0;
    logic [GPIO_W-1:0] gpio_dir1 = '0;
    logic [SW_W-1:0]   sw_o1, sw_rise1, sw_fall1;
    logic [GPIO_W-1:0] gpio_o1, gpio_edge1;

    gpio_input_conditioner #(
        .SW_W(SW_W), .GPIO_W(GPIO_W), .TICK_DIV(4), .STABLE_TICKS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sw_pad_i(sw_pad), .gpio_pad_i(gpio_pad), .gpio_dir_i(gpio_dir),
        .sw_o(sw_o), .gpio_o(gpio_o),
        .sw_rise_o(sw_rise), .sw_fall_o(sw_fall), .gpio_edge_o(gpio_edge)
    );

    gpio_input_conditioner #(
        .SW_W(SW_W), .GPIO_W(GPIO_W), .TICK_DIV(1), .STABLE_TICKS(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .sw_pad_i(sw_pad1), .gpio_pad_i(gpio_pad1), .gpio_dir_i(gpio_dir1),
        .sw_o(sw_o1), .gpio_o(gpio_o1),
        .sw_rise_o(sw_rise1), .sw_fall_o(sw_fall1), .gpio_edge_o(gpio_edge1)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int n_cmp = 0;
    int n_mis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 sw_rise, 1 sw_fall, 2 gpio_edge (dut); 3 sw_rise, 4 sw_fall, 5 gpio_edge (dut1)
    typedef struct {
        int kind;
        int bitn;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];

    task automatic push(input int k, input int b, input int lo, input int hi);
        exp_t e;
        e.kind = k; e.bitn = b; e.lo = lo; e.hi = hi;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int k, input int b);
        exp_t e;
        e.kind = -1; e.bitn = -1; e.lo = 0; e.hi = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        n_cmp++;
        assert (k == e.kind && b == e.bitn && cyc >= e.lo && cyc <= e.hi) else begin
            n_mis++;
            $error("FAIL pulse: observed kind %0d bit %0d cycle %0d, expected kind %0d bit %0d cycles %0d..%0d",
                   k, b, cyc, e.kind, e.bitn, e.lo, e.hi);
        end
    endtask

    // Pulse monitor: scans in the same order expectations are pushed.
    always @(negedge clk) begin
        for (int b = 0; b < SW_W; b++)   if (sw_rise[b])    check_event(0, b);
        for (int b = 0; b < SW_W; b++)   if (sw_fall[b])    check_event(1, b);
        for (int b = 0; b < GPIO_W; b++) if (gpio_edge[b])  check_event(2, b);
        for (int b = 0; b < SW_W; b++)   if (sw_rise1[b])   check_event(3, b);
        for (int b = 0; b < SW_W; b++)   if (sw_fall1[b])   check_event(4, b);
        for (int b = 0; b < GPIO_W; b++) if (gpio_edge1[b]) check_event(5, b);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Records the first cycle (negedge sample) at which the selected bit is 1.
    task automatic poll(input int n, input int sel, input int b, output int first);
        logic v;
        first = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v = (sel == 0) ? sw_o[b] : (sel == 1) ? gpio_o[b] : sw_o1[b];
            if (first < 0 && v) first = cyc;
        end
    endtask

    function automatic logic [63:0] all_out();
        return {sw_o, sw_rise, sw_fall, gpio_o, gpio_edge,
                sw_o1, sw_rise1, sw_fall1, gpio_o1, gpio_edge1};
    endfunction

    initial begin
        int c;
        int first;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        cycles(3);
        chk("reset_outputs", all_out(), 64'h0);
        rst_n = 1'b1;
        cycles(1);
        chk("first_edge_after_release", all_out(), 64'h0);

        // ---------------- all pads high, then async reset mid-cycle -----
        sw_pad   = 4'hF;
        gpio_pad = 12'hFFF;
        c = cyc;
        for (int b = 0; b < SW_W; b++)   push(0, b, c + 12, c + 15);
        for (int b = 0; b < GPIO_W; b++) push(2, b, c + 12, c + 15);
        poll(20, 0, 0, first);
        chk_rng("t1_sw_latency", first, c + 11, c + 14);
        chk("t1_sw_set", sw_o, 4'hF);
        chk("t1_gpio_set", gpio_o, 12'hFFF);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t1_async_reset", all_out(), 64'h0);
        cycles(2);
        chk("t1_held_in_reset", all_out(), 64'h0);
        rst_n = 1'b1;
        c = cyc;
        for (int b = 0; b < SW_W; b++)   push(0, b, c + 12, c + 15);
        for (int b = 0; b < GPIO_W; b++) push(2, b, c + 12, c + 15);
        poll(20, 0, 0, first);
        chk_rng("t1_release_latency", first, c + 11, c + 14);
        chk("t1_resettled_gpio", gpio_o, 12'hFFF);

        // ---------------- all pads low: fall pulses ---------------------
        sw_pad   = 4'h0;
        gpio_pad = 12'h000;
        c = cyc;
        for (int b = 0; b < SW_W; b++)   push(1, b, c + 12, c + 15);
        for (int b = 0; b < GPIO_W; b++) push(2, b, c + 12, c + 15);
        cycles(20);
        chk("fall_sw", sw_o, 4'h0);
        chk("fall_gpio", gpio_o, 12'h000);

        // ---------------- clean press on sw[0] ---------------------------
        sw_pad[0] = 1'b1;
        c = cyc;
        push(0, 0, c + 12, c + 15);
        poll(20, 0, 0, first);
        chk_rng("t2_press_latency", first, c + 11, c + 14);
        chk("t2_sw_o", sw_o, 4'h1);

        // ---------------- bounce on sw[1] --------------------------------
        repeat (3) begin
            sw_pad[1] = 1'b1;
            cycles(6);
            sw_pad[1] = 1'b0;
            cycles(6);
        end
        chk("t3_bounce_rejected", sw_o, 4'h1);
        sw_pad[1] = 1'b1;
        c = cyc;
        push(0, 1, c + 12, c + 15);
        cycles(20);
        chk("t3_held_accepted", sw_o, 4'h3);

        // ---------------- direction mask ---------------------------------
        gpio_dir = 12'h0F0;
        gpio_pad = 12'hFFF;
        c = cyc;
        for (int b = 0; b < 4; b++)  push(2, b, c + 12, c + 15);
        for (int b = 8; b < 12; b++) push(2, b, c + 12, c + 15);
        cycles(20);
        chk("t4_masked", gpio_o, 12'hF0F);

        gpio_dir = 12'h000;
        c = cyc;
        for (int b = 4; b < 8; b++) push(2, b, c + 10, c + 13);
        poll(20, 1, 4, first);
        chk_rng("t4_unmask_latency", first, c + 9, c + 12);
        chk("t4_unmasked", gpio_o, 12'hFFF);

        gpio_dir = 12'h0F0;
        c = cyc;
        for (int b = 4; b < 8; b++) push(2, b, c + 2, c + 2);
        cycles(1);
        chk("t4_remask_next_cycle", gpio_o, 12'hF0F);
        cycles(5);

        // ---------------- reset mid-count on sw[2] -----------------------
        sw_pad[2] = 1'b1;
        cycles(6);
        rst_n = 1'b0;
        cycles(2);
        chk("t5_reset_clears", all_out(), 64'h0);
        rst_n = 1'b1;
        c = cyc;
        for (int b = 0; b < 3; b++)  push(0, b, c + 12, c + 15);
        for (int b = 0; b < 4; b++)  push(2, b, c + 12, c + 15);
        for (int b = 8; b < 12; b++) push(2, b, c + 12, c + 15);
        poll(20, 0, 2, first);
        chk_rng("t5_full_latency", first, c + 11, c + 14);
        chk("t5_sw_o", sw_o, 4'h7);

        // ---------------- TICK_DIV=1, STABLE_TICKS=1 ---------------------
        sw_pad1[0] = 1'b1;
        c = cyc;
        push(3, 0, c + 4, c + 4);
        poll(8, 2, 0, first);
        chk("t6_exact_latency", first, c + 3);
        chk("t6_sw_o", sw_o1, 4'h1);
        chk("t6_gpio_idle", gpio_o1, 12'h000);

        cycles(5);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
